// File: rtl/rf_ctrl_pkg.sv
// rf_ctrl_pkg: shared sizes, FSM state type and requester ids for the
// register-file write-port control logic.
package rf_ctrl_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_NUM_REGS = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Requester ids double as bit positions in the grant vector and as pointer values.
    localparam logic REQ_ALU  = 1'b0;
    localparam logic REQ_LOAD = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant logic. The pointer names the requester
// that wins a tie; after any grant it moves to the requester that lost.
module rr_arb2
    import rf_ctrl_pkg::*;
(
    input  logic       valid0_i,
    input  logic       valid1_i,
    input  logic       en_i,
    input  logic       ptr_i,
    output logic [1:0] grant_o,
    output logic       ptr_nxt_o
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        grant_o   = 2'b00;
        ptr_nxt_o = ptr_i;
        if (en_i) begin
            if (valid0_i && valid1_i) begin
                grant_o[ptr_i] = 1'b1;
                ptr_nxt_o      = ~ptr_i;
            end else if (valid0_i) begin
                grant_o[REQ_ALU] = 1'b1;
                ptr_nxt_o        = REQ_LOAD;
            end else if (valid1_i) begin
                grant_o[REQ_LOAD] = 1'b1;
                ptr_nxt_o         = REQ_ALU;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: owns the register-file write port. Define RF_CLEAR_SEQ_EN
// to zero every register after reset before the two writeback requesters are served.
module regfile_write_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_REGS = RF_NUM_REGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr_reg,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              busy
);

    logic              in_clear;
    logic [ADDR_W-1:0] clear_reg;

`ifdef RF_CLEAR_SEQ_EN
    localparam int CNT_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_REGS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            if (cnt_q == CNT_LAST) begin
                state_d = RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign in_clear  = (state_q == CLEAR);
    assign clear_reg = ADDR_W'(cnt_q);
`else
    assign in_clear  = 1'b0;
    assign clear_reg = '0;
`endif

    logic       ptr_q, ptr_d;
    logic       arb_en;
    logic [1:0] grant;

    // Gating with reset keeps both readies low while reset is held, even in RUN.
    assign arb_en = reset && !in_clear;

    rr_arb2 u_arb (
        .valid0_i  (req0_valid),
        .valid1_i  (req1_valid),
        .en_i      (arb_en),
        .ptr_i     (ptr_q),
        .grant_o   (grant),
        .ptr_nxt_o (ptr_d)
    );

    assign req0_ready = grant[REQ_ALU];
    assign req1_ready = grant[REQ_LOAD];
    assign busy       = in_clear;

    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_reg_q, wr_reg_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    always_comb begin
        wr_en_d   = 1'b0;
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;
        if (in_clear) begin
            wr_en_d   = 1'b1;
            wr_reg_d  = clear_reg;
            wr_data_d = '0;
        end else if (grant[REQ_ALU]) begin
            // x0 writes are accepted to keep the requester moving but never strobed.
            wr_en_d   = (req0_addr != '0);
            wr_reg_d  = req0_addr;
            wr_data_d = req0_data;
        end else if (grant[REQ_LOAD]) begin
            wr_en_d   = (req1_addr != '0);
            wr_reg_d  = req1_addr;
            wr_data_d = req1_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q     <= REQ_ALU;
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign rf_wr_en   = wr_en_q;
    assign rf_wr_reg  = wr_reg_q;
    assign rf_wr_data = wr_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed and randomized checks of the write-port
// arbiter against a grant-history reference model; honours RF_CLEAR_SEQ_EN.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_reg;
    logic [31:0] rf_wr_data;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    regfile_write_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_reg  (rf_wr_reg),
        .rf_wr_data (rf_wr_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the requester granted most recently loses the next tie.
    int grant_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int tie_winner();
        if (grant_log.size() == 0) return 0;
        return 1 - grant_log[grant_log.size() - 1];
    endfunction

    // One clock cycle, entered just after a falling edge.
    task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                        output int g);
        logic        exp_en;
        logic [4:0]  exp_reg;
        logic [31:0] exp_data;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        #1;
        g = -1;
        if (v0 && v1)  g = tie_winner();
        else if (v0)   g = 0;
        else if (v1)   g = 1;
        check("req0_ready", {31'b0, req0_ready}, {31'b0, g == 0});
        check("req1_ready", {31'b0, req1_ready}, {31'b0, g == 1});
        check("busy_run", {31'b0, busy}, 32'd0);
        exp_en = 1'b0; exp_reg = '0; exp_data = '0;
        if (g >= 0) begin
            grant_log.push_back(g);
            exp_reg  = (g == 0) ? a0 : a1;
            exp_data = (g == 0) ? d0 : d1;
            exp_en   = (exp_reg != 5'd0);
        end
        @(posedge clk);
        @(negedge clk);
        check("rf_wr_en", {31'b0, rf_wr_en}, {31'b0, exp_en});
        if (exp_en) begin
            check("rf_wr_reg", {27'b0, rf_wr_reg}, {27'b0, exp_reg});
            check("rf_wr_data", rf_wr_data, exp_data);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wr_en"}, {31'b0, rf_wr_en}, 32'd0);
        check({tag, "_wr_reg"}, {27'b0, rf_wr_reg}, 32'd0);
        check({tag, "_wr_data"}, rf_wr_data, 32'd0);
        check({tag, "_ready0"}, {31'b0, req0_ready}, 32'd0);
        check({tag, "_ready1"}, {31'b0, req1_ready}, 32'd0);
    endtask

`ifdef RF_CLEAR_SEQ_EN
    // Entered just after the falling edge on which reset was released; req0 stays valid.
    task automatic clear_walk(input int n_cycles);
        for (int i = 0; i < n_cycles; i++) begin
            req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'hCAFE0009;
            #1;
            check("clear_busy", {31'b0, busy}, 32'd1);
            check("clear_ready0", {31'b0, req0_ready}, 32'd0);
            @(posedge clk);
            @(negedge clk);
            check("clear_wr_en", {31'b0, rf_wr_en}, 32'd1);
            check("clear_wr_reg", {27'b0, rf_wr_reg}, i);
            check("clear_wr_data", rf_wr_data, 32'd0);
        end
    endtask
`endif

    int          g;
    logic        pend_v[2];
    logic [4:0]  pend_a[2];
    logic [31:0] pend_d[2];

    initial begin
        reset = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h11111111;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h22222222;
        #2 reset = 1'b0;
        #1;
        check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        check_outputs_zero("reset_held");
        reset = 1'b1;
        req1_valid = 1'b0;

`ifdef RF_CLEAR_SEQ_EN
        // Interrupt the clear after ten writes; it must restart from register 0.
        clear_walk(10);
        reset = 1'b0;
        #1;
        check_outputs_zero("midclear");
        @(negedge clk);
        reset = 1'b1;
        clear_walk(32);
        step(1'b1, 5'd9, 32'hCAFE0009, 1'b0, 5'd0, 32'd0, g);
        check("first_run_grant", g, 0);
        grant_log.delete();
        // Leave the pointer at 0 again for the contention pattern.
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h66666666, g);
`else
        req0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, g);
        end
`endif

        // Contention with the pointer at 0: grants alternate 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 5'd1, 32'hA0000000 + i, 1'b1, 5'd2, 32'hB0000000 + i, g);
            check("contention_grant", g, i % 2);
        end

        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, g);
        check("single_grant", g, 0);

        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h00001234, g);
        check("x0_grant", g, 1);

        // Randomized traffic; a stalled requester keeps its transaction stable.
        pend_v[0] = 1'b0; pend_v[1] = 1'b0;
        for (int n = 0; n < 400; n++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend_v[r] && $urandom_range(0, 99) < 65) begin
                    pend_v[r] = 1'b1;
                    pend_a[r] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
                    pend_d[r] = $urandom;
                end
            end
            step(pend_v[0], pend_a[0], pend_d[0], pend_v[1], pend_a[1], pend_d[1], g);
            if (g >= 0) pend_v[g] = 1'b0;
        end

        // Make the pointer favour req1, then reset with a write granted but not yet registered.
        step(1'b1, 5'd8, 32'h88888888, 1'b0, 5'd0, 32'd0, g);
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77777777;
        req1_valid = 1'b0;
        #1;
        check("pre_reset_ready0", {31'b0, req0_ready}, 32'd1);
        reset = 1'b0;
        #1;
        check_outputs_zero("midxfer");
        @(posedge clk);
        @(negedge clk);
        check("dropped_wr_en", {31'b0, rf_wr_en}, 32'd0);
        reset = 1'b1;
        grant_log.delete();
`ifdef RF_CLEAR_SEQ_EN
        clear_walk(32);
`endif
        step(1'b1, 5'd10, 32'h0A0A0A0A, 1'b1, 5'd11, 32'h0B0B0B0B, g);
        check("post_reset_ptr", g, 0);
        step(1'b1, 5'd10, 32'h0A0A0A0A, 1'b1, 5'd11, 32'h0B0B0B0B, g);
        check("post_reset_alt", g, 1);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, g);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
